alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: reads two operands from an external register file,
// executes one of eight operations (MUL is an 8-step shift-add) and writes back.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] opcode,
    input  logic [3:0] dst,
    input  logic [3:0] src_a,
    input  logic [3:0] src_b,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [3:0] A_sel,
    output logic [3:0] B_sel,
    output logic [3:0] replaceSel,
    output logic [7:0] replaceData,
    output logic       done,
    output logic       carry,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MUL, OP_MOV
    } op_t;

    state_t      state_q;
    op_t         op_q;
    logic [3:0]  dst_q, src_a_q, src_b_q;
    logic [7:0]  result_q, mcand_q;
    logic [15:0] prod_q, prod_d;
    logic [2:0]  cnt_q;
    logic        done_q, carry_q, zero_q;

    logic [8:0]  alu_wide;
    logic [8:0]  mul_sum;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        alu_wide = 9'd0;
        case (op_q)
            OP_ADD:  alu_wide = {1'b0, A} + {1'b0, B};
            OP_SUB:  alu_wide = {1'b0, A} - {1'b0, B};
            OP_AND:  alu_wide = {1'b0, A & B};
            OP_OR:   alu_wide = {1'b0, A | B};
            OP_XOR:  alu_wide = {1'b0, A ^ B};
            OP_SHL:  alu_wide = {1'b0, A} << B[2:0];
            OP_MOV:  alu_wide = {1'b0, A};
            default: alu_wide = 9'd0;
        endcase
    end

    // Multiplier sits in the low half of prod_q and shifts out as the partial sum grows.
    always_comb begin
        mul_sum = {1'b0, prod_q[15:8]} + (prod_q[0] ? {1'b0, mcand_q} : 9'd0);
        prod_d  = {mul_sum, prod_q[7:1]};
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            dst_q    <= 4'd0;
            src_a_q  <= 4'd0;
            src_b_q  <= 4'd0;
            result_q <= 8'd0;
            mcand_q  <= 8'd0;
            prod_q   <= 16'd0;
            cnt_q    <= 3'd0;
            done_q   <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        op_q    <= op_t'(opcode);
                        dst_q   <= dst;
                        src_a_q <= src_a;
                        src_b_q <= src_b;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (op_q == OP_MUL) begin
                        mcand_q <= A;
                        prod_q  <= {8'h00, B};
                        cnt_q   <= 3'd0;
                        state_q <= EXEC;
                    end else begin
                        result_q <= alu_wide[7:0];
                        carry_q  <= alu_wide[8];
                        zero_q   <= (alu_wide[7:0] == 8'd0);
                        done_q   <= 1'b1;
                        state_q  <= WRITE;
                    end
                end
                EXEC: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_q <= prod_d[7:0];
                        carry_q  <= |prod_d[15:8];
                        zero_q   <= (prod_d[7:0] == 8'd0);
                        done_q   <= 1'b1;
                        state_q  <= WRITE;
                    end
                end
                WRITE: begin
                    src_a_q <= 4'd0;
                    src_b_q <= 4'd0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign A_sel       = src_a_q;
    assign B_sel       = src_b_q;
    assign done        = done_q;
    assign carry       = carry_q;
    assign zero        = zero_q;

    // Outside WRITE the register file is fed its own A-port value, making the write a no-op.
    assign replaceSel  = (state_q == WRITE) ? dst_q    : src_a_q;
    assign replaceData = (state_q == WRITE) ? result_q : A;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: register-file model, directed cases and random
// instructions compared against an arithmetic reference model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic [3:0] dst, src_a, src_b;
    logic [7:0] A, B;
    logic [3:0] A_sel, B_sel, replaceSel;
    logic [7:0] replaceData;
    logic       done, carry, zero;

    logic [7:0] rf     [16];
    logic [7:0] exp_rf [16];
    logic       pre_en;
    logic [3:0] pre_idx;
    logic [7:0] pre_data;

    int checks   = 0;
    int failures = 0;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .dst         (dst),
        .src_a       (src_a),
        .src_b       (src_b),
        .A           (A),
        .B           (B),
        .A_sel       (A_sel),
        .B_sel       (B_sel),
        .replaceSel  (replaceSel),
        .replaceData (replaceData),
        .done        (done),
        .carry       (carry),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // External register file: written on every edge; the bench can preload it.
    always @(posedge clk) begin
        if (pre_en) rf[pre_idx] <= pre_data;
        else        rf[replaceSel] <= replaceData;
    end
    assign A = rf[A_sel];
    assign B = rf[B_sel];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int c);
        int full;
        int s;
        s = b % 8;
        c = 0;
        case (op)
            0: begin full = a + b; c = (full > 255) ? 1 : 0; end
            1: begin full = a - b; c = (a < b) ? 1 : 0; end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: begin full = a * (1 << s); c = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
            6: begin full = a * b; c = (full > 255) ? 1 : 0; end
            default: full = a;
        endcase
        res = ((full % 256) + 256) % 256;
    endfunction

    task automatic preload(input int idx, input int val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 4'(idx); pre_data = 8'(val);
        @(negedge clk);
        pre_en = 1'b0;
        exp_rf[idx] = 8'(val);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_r%0d", tag, i), {8'h00, rf[i]}, {8'h00, exp_rf[i]});
    endtask

    // Issue one instruction from IDLE (called at a falling edge) and follow it to completion.
    task automatic run_instr(input string tag, input int op, input int d, input int sa, input int sb);
        int res, c, lat, done_at, ready_hi;
        model(op, int'(exp_rf[sa]), int'(exp_rf[sb]), res, c);
        lat = (op == 6) ? 10 : 2;
        done_at = -1;
        ready_hi = 0;
        check({tag, "_ready_at_issue"}, {15'd0, instr_ready}, 16'd1);
        instr_valid = 1'b1; opcode = 3'(op); dst = 4'(d); src_a = 4'(sa); src_b = 4'(sb);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        opcode = 3'($urandom); dst = 4'($urandom); src_a = 4'($urandom); src_b = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (instr_ready) ready_hi++;
            if (done && done_at < 0) done_at = k;
            if (k == 1) begin
                check({tag, "_asel"}, {12'd0, A_sel}, 16'(sa));
                check({tag, "_bsel"}, {12'd0, B_sel}, 16'(sb));
                check({tag, "_refresh_data"}, {8'h00, replaceData}, {8'h00, exp_rf[sa]});
            end
            if (k == lat) begin
                check({tag, "_wsel"}, {12'd0, replaceSel}, 16'(d));
                check({tag, "_wdata"}, {8'h00, replaceData}, 16'(res));
            end
        end
        check({tag, "_done_cycle"}, 16'(done_at), 16'(lat));
        check({tag, "_busy_ready"}, 16'(ready_hi), 16'd0);
        exp_rf[d] = 8'(res);
        @(negedge clk);
        check({tag, "_rf_dst"}, {8'h00, rf[d]}, 16'(res));
        check({tag, "_carry"}, {15'd0, carry}, 16'(c));
        check({tag, "_zero"}, {15'd0, zero}, (res == 0) ? 16'd1 : 16'd0);
        check({tag, "_done_off"}, {15'd0, done}, 16'd0);
        check({tag, "_idle_asel"}, {12'd0, A_sel}, 16'd0);
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0;
        dst = 4'd0; src_a = 4'd0; src_b = 4'd0;
        pre_en = 1'b0; pre_idx = 4'd0; pre_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_done",  {15'd0, done},  16'd0);
        check("rst_carry", {15'd0, carry}, 16'd0);
        check("rst_zero",  {15'd0, zero},  16'd0);
        check("rst_asel",  {12'd0, A_sel}, 16'd0);
        check("rst_bsel",  {12'd0, B_sel}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {15'd0, instr_ready}, 16'd1);

        for (int i = 0; i < 16; i++) preload(i, (i * 37 + 11) % 256);

        preload(1, 200); preload(2, 100);
        run_instr("add", 0, 3, 1, 2);

        preload(4, 5); preload(5, 7);
        run_instr("sub1", 1, 6, 4, 5);
        run_instr("sub2", 1, 6, 5, 4);

        preload(1, 16); preload(2, 17);
        run_instr("mul", 6, 7, 1, 2);

        preload(8, 8'h81); preload(9, 1);
        run_instr("shl", 5, 8, 8, 9);
        run_instr("xor", 4, 10, 8, 8);

        run_instr("dep_add", 0, 11, 11, 11);
        run_instr("dep_mov", 7, 12, 11, 3);

        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) preload($urandom_range(0, 15), $urandom_range(0, 255));
            run_instr($sformatf("rnd%0d", n), $urandom_range(0, 7), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
        end

        for (int i = 0; i < 16; i++) preload(i, 8'hA0 + i);
        repeat (20) @(negedge clk);
        check_rf("idle");

        preload(13, 200); preload(14, 3);
        instr_valid = 1'b1; opcode = 3'd6; dst = 4'd15; src_a = 4'd13; src_b = 4'd14;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_done",  {15'd0, done},  16'd0);
        check("abort_carry", {15'd0, carry}, 16'd0);
        check("abort_zero",  {15'd0, zero},  16'd0);
        check("abort_asel",  {12'd0, A_sel}, 16'd0);
        check("abort_wsel",  {12'd0, replaceSel}, 16'd0);
        done_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", 16'(done_cnt), 16'd0);
        check("abort_ready", {15'd0, instr_ready}, 16'd1);
        check("abort_flags", {14'd0, carry, zero}, 16'd0);
        check_rf("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
